// File: rtl/datamemory_lsu_if.sv
// Core-side load/store bus of the byte-addressed data memory (request in, result/status out).
// Pure wiring; busy tells the master to hold off, rd/rd_valid/fault are registered in the memory.
interface datamemory_lsu_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DM_ADDRESS+1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     rd;
    logic                  rd_valid;
    logic                  busy;
    logic                  fault;

    modport master (
        output MemRead, MemWrite, Funct3, a, wd,
        input  rd, rd_valid, busy, fault
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, a, wd,
        output rd, rd_valid, busy, fault
    );
endinterface

// File: rtl/datamemory_lsu.sv
// RV32 byte-lane data memory (LB/LH/LW/LBU/LHU/SB/SH/SW); DM_MISALIGN_CHECK_EN faults misaligned accesses.
// Latency: access at edge k+1+WAIT_STATES after request edge k; rd/rd_valid in the following cycle.
// Backpressure: busy high for WAIT_STATES+1 cycles; requests are ignored while busy.
module datamemory_lsu #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input logic             clk,
    input logic             reset,
    datamemory_lsu_if.slave bus
);
    localparam int          AW     = DM_ADDRESS + 2;
    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  ACCESS = 1'b1;
    localparam logic [2:0]  WS     = 3'(WAIT_STATES);

    logic [0:0]        state;
    logic [2:0]        cnt;
    logic [AW-1:0]     lat_a;
    logic [DATA_W-1:0] lat_wd;
    logic [2:0]        lat_f3;
    logic              lat_load;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid_q;
    logic              fault_q;

    logic [DATA_W-1:0] mem [0:(1<<DM_ADDRESS)-1];

    logic              req;
    logic              f3_legal;
    logic              reject;
    logic              accept;
    logic [AW-1:0]     a_eff;
`ifdef DM_MISALIGN_CHECK_EN
    logic              misaligned;
`endif

    always_comb begin
        req      = bus.MemRead ^ bus.MemWrite;
        f3_legal = 1'b0;
        if (bus.MemRead) begin
            case (bus.Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else begin
            f3_legal = (bus.Funct3 <= 3'b010);
        end
        a_eff = bus.a;
`ifdef DM_MISALIGN_CHECK_EN
        misaligned = ((bus.Funct3[1:0] == 2'b01) && bus.a[0]) ||
                     ((bus.Funct3[1:0] == 2'b10) && (bus.a[1:0] != 2'b00));
        reject = req && (!f3_legal || misaligned);
`else
        // Misaligned halfword/word accesses are silently aligned down.
        if (bus.Funct3[1:0] == 2'b01) a_eff[0]   = 1'b0;
        if (bus.Funct3[1:0] == 2'b10) a_eff[1:0] = 2'b00;
        reject = req && !f3_legal;
`endif
        accept = req && !reject;
    end

    logic [DM_ADDRESS-1:0] word_idx;
    logic [DATA_W-1:0]     cur;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     load_val;
    logic [3:0]            wmask;
    logic [DATA_W-1:0]     wbytes;
    logic [DATA_W-1:0]     merged;
    logic                  do_access;

    always_comb begin
        word_idx  = lat_a[AW-1:2];
        cur       = mem[word_idx];
        byte_sel  = cur[{lat_a[1:0], 3'b000} +: 8];
        half_sel  = lat_a[1] ? cur[31:16] : cur[15:0];
        case (lat_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = cur;
        endcase
        case (lat_f3)
            3'b000:  begin wmask = 4'b0001 << lat_a[1:0];              wbytes = {4{lat_wd[7:0]}};  end
            3'b001:  begin wmask = lat_a[1] ? 4'b1100 : 4'b0011;       wbytes = {2{lat_wd[15:0]}}; end
            default: begin wmask = 4'b1111;                            wbytes = lat_wd;            end
        endcase
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = wmask[i] ? wbytes[8*i +: 8] : cur[8*i +: 8];
        do_access = (state == ACCESS) && (cnt == 3'd0);
    end

    // Gated by reset so a store interrupted by reset never lands.
    always_ff @(posedge clk) begin
        if (!reset && do_access && !lat_load)
            mem[word_idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            lat_a      <= '0;
            lat_wd     <= '0;
            lat_f3     <= 3'd0;
            lat_load   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            fault_q    <= (state == IDLE) && reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_a    <= a_eff;
                        lat_wd   <= bus.wd;
                        lat_f3   <= bus.Funct3;
                        lat_load <= bus.MemRead;
                        cnt      <= WS;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= IDLE;
                        if (lat_load) begin
                            rd_q       <= load_val;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ACCESS);
    assign bus.rd       = rd_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_datamemory_lsu.sv
// Scoreboard bench for datamemory_lsu: byte-array reference model, directed plan plus random traffic.
module tb_datamemory_lsu;
    localparam int DMA = 9;
    localparam int WS  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    datamemory_lsu_if #(.DM_ADDRESS(DMA), .DATA_W(32)) bus();

    datamemory_lsu #(.DM_ADDRESS(DMA), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_load;
        logic [31:0] v;
    } exp_t;

    exp_t       q[$];
    logic [7:0] bm [0:2047];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid or fault pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1 || bus.fault === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: rd_valid=%b fault=%b rd=%h with nothing expected",
                         bus.rd_valid, bus.fault, bus.rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_kind", {30'd0, bus.rd_valid, bus.fault}, e.is_load ? 32'd2 : 32'd1);
                if (e.is_load) check("load_data", bus.rd, e.v);
            end
        end
    end

    task automatic op(input logic r, input logic w, input logic [2:0] f3,
                      input logic [10:0] addr, input logic [31:0] wdat);
        logic        legal, acc;
        logic [10:0] ea;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v, rd_before;
        int          n;
        legal = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        ea    = addr;
`ifdef DM_MISALIGN_CHECK_EN
        acc = (r ^ w) && legal &&
              !(((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
        acc = (r ^ w) && legal;
        if (f3[1:0] == 2'b01) ea = addr & ~11'd1;
        if (f3[1:0] == 2'b10) ea = addr & ~11'd3;
`endif
        if ((r ^ w) && !acc) begin
            q.push_back('{1'b0, 32'd0});
        end else if (acc && w) begin
            case (f3)
                3'd0: bm[ea] = wdat[7:0];
                3'd1: begin bm[ea] = wdat[7:0]; bm[ea+1] = wdat[15:8]; end
                default: for (int i = 0; i < 4; i++) bm[ea+i] = wdat[8*i +: 8];
            endcase
        end else if (acc && r) begin
            b = bm[ea];
            h = {bm[ea+1], bm[ea]};
            case (f3)
                3'd0:    v = {{24{b[7]}}, b};
                3'd4:    v = {24'd0, b};
                3'd1:    v = {{16{h[15]}}, h};
                3'd5:    v = {16'd0, h};
                default: v = {bm[ea+3], bm[ea+2], bm[ea+1], bm[ea]};
            endcase
            q.push_back('{1'b1, v});
        end

        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin n++; @(negedge clk); end
        rd_before    = bus.rd;
        bus.MemRead  = r;
        bus.MemWrite = w;
        bus.Funct3   = f3;
        bus.a        = addr;
        bus.wd       = wdat;
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 50) begin n++; @(negedge clk); end
        check("busy_cycles", n, acc ? WS + 1 : 0);
        if (acc && r) check("rd_valid_after_busy", {31'd0, bus.rd_valid}, 32'd1);
        if (!acc)     check("rd_hold", bus.rd, rd_before);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Funct3   = 3'd0;
        bus.a        = '0;
        bus.wd       = '0;
        repeat (3) @(negedge clk);
        check("reset_rd", bus.rd, 32'd0);
        check("reset_flags", {29'd0, bus.rd_valid, bus.busy, bus.fault}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 3'd2, 11'(4 * i), $urandom);

        op(1'b0, 1'b1, 3'd2, 11'h010, 32'h12345678);
        op(1'b1, 1'b0, 3'd2, 11'h010, 32'd0);
        op(1'b0, 1'b1, 3'd0, 11'h011, 32'h000000AB);
        op(1'b1, 1'b0, 3'd2, 11'h010, 32'd0);
        op(1'b0, 1'b1, 3'd1, 11'h012, 32'h0000BEEF);
        op(1'b1, 1'b0, 3'd2, 11'h010, 32'd0);
        op(1'b1, 1'b0, 3'd0, 11'h011, 32'd0);
        op(1'b1, 1'b0, 3'd4, 11'h011, 32'd0);
        op(1'b1, 1'b0, 3'd1, 11'h012, 32'd0);
        op(1'b1, 1'b0, 3'd5, 11'h012, 32'd0);
        op(1'b1, 1'b0, 3'd3, 11'h010, 32'd0);
        op(1'b1, 1'b0, 3'd2, 11'h013, 32'd0);
        op(1'b0, 1'b1, 3'd1, 11'h011, 32'h00005555);
        op(1'b1, 1'b0, 3'd2, 11'h010, 32'd0);
        op(1'b1, 1'b1, 3'd2, 11'h010, 32'd0);

        // Store interrupted by reset must leave the old word in place.
        op(1'b0, 1'b1, 3'd2, 11'h020, 32'h11111111);
        bus.MemWrite = 1'b1;
        bus.Funct3   = 3'd2;
        bus.a        = 11'h020;
        bus.wd       = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_rd", bus.rd, 32'd0);
        check("post_reset_flags", {29'd0, bus.rd_valid, bus.busy, bus.fault}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        op(1'b1, 1'b0, 3'd2, 11'h020, 32'd0);

        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 19);
            op(k < 9 || k >= 18, k >= 9, 3'($urandom_range(0, 7)),
               11'($urandom_range(0, 63)), $urandom);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/datamemory_lsu.md
Name: datamemory_lsu

Overview:
Parametrised successor to the single-port word data memory. Byte-addressed and RISC-V load/store aware: it handles LB/LH/LW/LBU/LHU/SB/SH/SW using byte lanes, sign/zero extension and configurable wait states. A busy/rd_valid handshake lets the core stall. It sits between the ALU address output and the writeback mux, in place of the plain data memory.

Parameters:
DM_ADDRESS, 9, word-address bits; depth = 2**DM_ADDRESS words
DATA_W, 32, word width; fixed at 32 for RV32 byte-lane logic
WAIT_STATES, 1, extra access cycles, 0..7

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
MemRead  input  1  load request
MemWrite  input  1  store request
Funct3  input  3  load/store size and sign (RV32I encoding)
a  input  DM_ADDRESS+2  byte address
wd  input  DATA_W  store data; low bytes used for SB/SH
rd  output  DATA_W  extended load result, registered
rd_valid  output  1  one-cycle pulse when rd is updated by a load
busy  output  1  access in progress; core must stall
fault  output  1  one-cycle pulse on a rejected request

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: rd=0, rd_valid=0, busy=0, fault=0, state=IDLE, cnt=0. Memory contents are not cleared.
- Valid request: exactly one of MemRead/MemWrite is high. Both high is ignored: no state change, no fault.
- FSM states: IDLE and ACCESS.
- IDLE: busy=0. On an edge with a valid, legal request, latch a, wd, Funct3 and op; set cnt<=WAIT_STATES; go to ACCESS.
- Illegal or rejected request: no latch. fault=1 for the following cycle. State stays IDLE. rd and memory are unchanged.
- ACCESS: busy=1.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: perform the access at this edge and return to IDLE.
- Latency: request sampled at edge k; access at edge k+1+WAIT_STATES; rd/rd_valid visible in the cycle that follows. busy is high for WAIT_STATES+1 cycles.
- A new request can be accepted in the cycle rd_valid is high. Request inputs are don't-care while busy.
- Store lanes: word = a[DM_ADDRESS+1:2]. Other bytes are untouched.
  - SB (000): byte lane a[1:0] <= wd[7:0].
  - SH (001): lanes {a[1],0} and {a[1],1} <= wd[15:0].
  - SW (010): full word.
- Load extraction:
  - LB (000): byte, sign-extended from bit 7.
  - LH (001): halfword, sign-extended from bit 15.
  - LW (010): full word.
  - LBU (100): byte, zero-extended.
  - LHU (101): halfword, zero-extended.
- Little-endian: byte 0 = bits 7:0.
- Illegal Funct3: loads 011/110/111, stores 011 and up. Always rejected with fault.
- rd holds the last load result. Stores never change rd; rd_valid stays 0 for stores.
- Address range: the full port width maps to memory, so there is no out-of-range case.
- reset during ACCESS: return to IDLE immediately. A pending store is dropped (memory unchanged) and a pending load is discarded.

Optional Feature:
Macro DM_MISALIGN_CHECK_EN.
- Defined: misaligned requests are rejected with a fault pulse and no memory access. Misaligned means half-word with a[0]=1, or word with a[1:0]!=0.
- Undefined: no misalignment fault. Offending low address bits are forced to 0 (a[0] for halfwords, a[1:0] for words) and the access proceeds aligned.
- Illegal-Funct3 faults are reported in both builds.

Test Plan:
- Word round trip, WAIT_STATES=1: SW 0x12345678 @0x010, then LW @0x010 -> rd=0x12345678. rd_valid is a single pulse; busy is high 2 cycles per access.
- Byte/half stores: SB wd=0xAB @0x011, then LW @0x010 -> 0x1234AB78. SH wd=0xBEEF @0x012, then LW -> 0xBEEFAB78.
- Extension: LB @0x011 -> 0xFFFFFFAB. LBU @0x011 -> 0x000000AB. LH @0x012 -> 0xFFFFBEEF. LHU @0x012 -> 0x0000BEEF.
- Wait states, WAIT_STATES=3: busy high exactly 4 cycles. rd_valid is high in the 5th cycle after the request edge. A back-to-back load accepted in that cycle completes correctly.
- Faults:
  - Funct3=011 load -> fault pulse, rd unchanged, busy stays 0.
  - With DM_MISALIGN_CHECK_EN: LW @0x013 -> fault, and SH @0x011 leaves memory unchanged.
  - Without the macro: LW @0x013 returns the word at 0x010.
- Reset/conflict:
  - SW 0xDEADBEEF @0x020 over 0x11111111, reset during busy -> LW @0x020 returns 0x11111111, and all outputs are 0 after reset.
  - MemRead=MemWrite=1 -> no busy, no fault.
